// File: rtl/cmd_sequencer.sv
// cmd_sequencer: owns the robot command memory and replays a stored program.
//
// In PROG the block records direction commands from the switches (save_pulse).
// exec_pulse replays the stored commands in order, holding each one on cmd_out
// for STEP_CYCLES cycles with a one-cycle gap between commands. clear_pulse
// aborts any playback and wipes the whole memory, one slot per cycle.
//
// Control inputs are single-cycle pulses, not handshakes. A pulse is acted on
// only in the cycle it is high and only in a state that accepts it; there is
// no back-pressure, so a pulse arriving in a state that ignores it is dropped.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   save_pulse    store cmd_in at mem[count] (PROG only)
//   exec_pulse    start playback (PROG only)
//   clear_pulse   abort and wipe (any state except CLEAR)
//   cmd_in        command to store
//   cmd_out       command currently executing
//   cmd_valid     cmd_out is live
//   count         number of stored commands, 0..DEPTH
//   step_idx      index of the command currently executing
//   busy          high in CLEAR, LOAD, HOLD
//   done          one-cycle pulse at end of playback
//   full_err      sticky: save attempted with memory full
//   state_dbg     current FSM state encoding, for checkers
module cmd_sequencer #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int CMD_W       = 2,
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_pulse,
    input  logic              exec_pulse,
    input  logic              clear_pulse,
    input  logic [CMD_W-1:0]  cmd_in,
    output logic [CMD_W-1:0]  cmd_out,
    output logic              cmd_valid,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] step_idx,
    output logic              busy,
    output logic              done,
    output logic              full_err,
    output logic [2:0]        state_dbg
);

    // A STEP_CYCLES of 1 still needs a 1-bit timer that just holds 0.
    localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(STEP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [ADDR_W:0]    COUNT_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_PROG  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     count_nxt;
    logic [ADDR_W-1:0]   step_idx_nxt;
    logic [CMD_W-1:0]    cmd_out_nxt;
    logic                cmd_valid_nxt;
    logic                done_nxt;
    logic                full_err_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [ADDR_W-1:0]   clr_addr, clr_addr_nxt;

    // Single-port RAM signals.
    logic [CMD_W-1:0]    mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [CMD_W-1:0]    mem_wdata;
    logic [CMD_W-1:0]    rd_data;

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        step_idx_nxt  = step_idx;
        cmd_out_nxt   = cmd_out;
        cmd_valid_nxt = cmd_valid;
        done_nxt      = 1'b0;
        full_err_nxt  = full_err;
        timer_nxt     = timer;
        clr_addr_nxt  = clr_addr;
        mem_we        = 1'b0;
        mem_wdata     = cmd_in;

        unique case (state)
            S_PROG: begin
                if (clear_pulse) begin
                    full_err_nxt = 1'b0;
                    state_nxt    = S_CLEAR;
                end else if (exec_pulse) begin
                    if (count != '0) begin
                        step_idx_nxt = '0;
                        state_nxt    = S_LOAD;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end else if (save_pulse) begin
                    if (count == COUNT_MAX) begin
                        full_err_nxt = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        count_nxt = count + COUNT_ONE;
                    end
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                if (clr_addr == ADDR_LAST) begin
                    count_nxt    = '0;
                    step_idx_nxt = '0;
                    clr_addr_nxt = '0;
                    state_nxt    = S_PROG;
                end else begin
                    clr_addr_nxt = clr_addr + ADDR_ONE;
                end
            end
            S_LOAD: begin
                if (clear_pulse) begin
                    cmd_valid_nxt = 1'b0;
                    full_err_nxt  = 1'b0;
                    state_nxt     = S_CLEAR;
                end else begin
                    cmd_out_nxt   = rd_data;
                    cmd_valid_nxt = 1'b1;
                    timer_nxt     = TIMER_LOAD;
                    state_nxt     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (clear_pulse) begin
                    cmd_valid_nxt = 1'b0;
                    full_err_nxt  = 1'b0;
                    state_nxt     = S_CLEAR;
                end else if (timer == '0) begin
                    cmd_valid_nxt = 1'b0;
                    if ({1'b0, step_idx} == count - COUNT_ONE) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_FIN;
                    end else begin
                        step_idx_nxt = step_idx + ADDR_ONE;
                        state_nxt    = S_LOAD;
                    end
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            S_FIN: begin
                if (clear_pulse) begin
                    full_err_nxt = 1'b0;
                    state_nxt    = S_CLEAR;
                end else begin
                    state_nxt = S_PROG;
                end
            end
            default: state_nxt = S_PROG;
        endcase

        // The RAM output is registered, so the read address is driven with the
        // step index of the *next* cycle: the data is then already on rd_data
        // while in LOAD and can be captured into cmd_out on LOAD exit.
        if (state == S_CLEAR) begin
            mem_addr = clr_addr;
        end else if (mem_we) begin
            mem_addr = count[ADDR_W-1:0];
        end else begin
            mem_addr = step_idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_PROG;
            count     <= '0;
            step_idx  <= '0;
            cmd_out   <= '0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            full_err  <= 1'b0;
            timer     <= '0;
            clr_addr  <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            step_idx  <= step_idx_nxt;
            cmd_out   <= cmd_out_nxt;
            cmd_valid <= cmd_valid_nxt;
            done      <= done_nxt;
            full_err  <= full_err_nxt;
            timer     <= timer_nxt;
            clr_addr  <= clr_addr_nxt;
        end
    end

    // No reset on the array or its read register so it maps onto block RAM;
    // count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_data <= mem[mem_addr];
    end

    assign busy      = (state == S_CLEAR) || (state == S_LOAD) || (state == S_HOLD);
    assign state_dbg = state;

endmodule

// File: tb/tb_cmd_sequencer.sv
module tb_cmd_sequencer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CMD_W  = 2;
    localparam int STEP   = 4;
    localparam int SLOT   = STEP + 1;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              save_pulse = 1'b0;
    logic              exec_pulse = 1'b0;
    logic              clear_pulse = 1'b0;
    logic [CMD_W-1:0]  cmd_in = '0;
    logic [CMD_W-1:0]  cmd_out;
    logic              cmd_valid;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] step_idx;
    logic              busy;
    logic              done;
    logic              full_err;
    logic [2:0]        state_dbg;

    always #5 clk = ~clk;

    cmd_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk), .rst(rst),
        .save_pulse(save_pulse), .exec_pulse(exec_pulse), .clear_pulse(clear_pulse),
        .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_valid(cmd_valid),
        .count(count), .step_idx(step_idx), .busy(busy), .done(done),
        .full_err(full_err), .state_dbg(state_dbg)
    );

    // ---------------- reference model ----------------
    // The stored program is just a queue of commands; full_err is a flag.
    logic [CMD_W-1:0] exp_q[$];
    logic             m_full_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_save(input logic [CMD_W-1:0] c);
        save_pulse = 1'b1;
        cmd_in     = c;
        tick();
        save_pulse = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(c);
        else m_full_err = 1'b1;
        chk("save_count", 32'(count), 32'(exp_q.size()));
        chk("save_full_err", 32'(full_err), 32'(m_full_err));
    endtask

    // Called in the first cycle after the edge that sampled a clear request.
    task automatic clear_tail();
        for (int k = 1; k <= DEPTH; k++) begin
            chk("clr_busy", 32'(busy), 32'd1);
            chk("clr_valid", 32'(cmd_valid), 32'd0);
            chk("clr_done", 32'(done), 32'd0);
            tick();
        end
        chk("clr_end_busy", 32'(busy), 32'd0);
        chk("clr_end_count", 32'(count), 32'd0);
        chk("clr_end_full_err", 32'(full_err), 32'd0);
    endtask

    task automatic do_clear();
        clear_pulse = 1'b1;
        tick();
        clear_pulse = 1'b0;
        exp_q.delete();
        m_full_err = 1'b0;
        clear_tail();
    endtask

    // Playback timeline from the cycle after exec is sampled: command i
    // occupies slot i of SLOT cycles (one load cycle, then STEP valid cycles),
    // and done is high in the single cycle after the last slot.
    task automatic run_exec(input int save_at, input int abort_at);
        int n;
        int total;
        n     = exp_q.size();
        total = n * SLOT + 2;
        exec_pulse = 1'b1;
        tick();
        exec_pulse = 1'b0;
        for (int k = 1; k <= total; k++) begin
            int  p;
            int  idx;
            int  off;
            bit  act;
            bit  exp_valid;
            p         = k - 1;
            idx       = p / SLOT;
            off       = p % SLOT;
            act       = (n > 0) && (k <= n * SLOT);
            exp_valid = act && (off >= 1);
            chk("play_valid", 32'(cmd_valid), 32'(exp_valid));
            chk("play_done", 32'(done), 32'(k == n * SLOT + 1));
            chk("play_busy", 32'(busy), 32'(act));
            chk("play_count", 32'(count), 32'(n));
            if (exp_valid) chk("play_cmd", 32'(cmd_out), 32'(exp_q[idx]));
            if (n > 0 && k <= n * SLOT + 1)
                chk("play_step", 32'(step_idx), 32'((idx < n) ? idx : n - 1));
            if (k == abort_at) begin
                clear_pulse = 1'b1;
                tick();
                clear_pulse = 1'b0;
                exp_q.delete();
                m_full_err = 1'b0;
                clear_tail();
                return;
            end
            if (k == save_at) begin
                save_pulse = 1'b1;
                cmd_in     = CMD_W'($urandom_range(0, 3));
            end
            tick();
            save_pulse = 1'b0;
        end
        if (n > 0) chk("play_hold_cmd", 32'(cmd_out), 32'(exp_q[n-1]));
        chk("play_end_count", 32'(count), 32'(n));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        m_full_err = 1'b0;

        // Reset state
        #2;
        chk("rst_cmd_out", 32'(cmd_out), 32'd0);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_step", 32'(step_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_full_err", 32'(full_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Empty exec: immediate done, never valid, never busy
        run_exec(0, 0);

        // Record/play 00,01,11 with a save dropped during HOLD of step 0
        do_save(2'b00);
        do_save(2'b01);
        do_save(2'b11);
        run_exec(3, 0);
        do_clear();

        // Full: nine random saves, the ninth sets full_err
        for (int i = 0; i < DEPTH + 1; i++) do_save(CMD_W'($urandom_range(0, 3)));
        chk("full_count", 32'(count), 32'(DEPTH));
        run_exec(0, 0);
        do_clear();

        // Random programs
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) do_save(CMD_W'($urandom_range(0, 3)));
            run_exec(0, 0);
            do_clear();
        end

        // Abort during HOLD of step 1, then an empty exec
        for (int i = 0; i < 3; i++) do_save(CMD_W'($urandom_range(0, 3)));
        run_exec(0, SLOT + 3);
        run_exec(0, 0);

        // clear+exec+save together in PROG: clear wins, nothing stored
        do_save(CMD_W'($urandom_range(0, 3)));
        do_save(CMD_W'($urandom_range(0, 3)));
        c0 = exp_q.size();
        clear_pulse = 1'b1;
        exec_pulse  = 1'b1;
        save_pulse  = 1'b1;
        cmd_in      = CMD_W'($urandom_range(0, 3));
        tick();
        clear_pulse = 1'b0;
        exec_pulse  = 1'b0;
        save_pulse  = 1'b0;
        chk("sim_count", 32'(count), 32'(c0));
        exp_q.delete();
        m_full_err = 1'b0;
        clear_tail();

        // Asynchronous reset in the middle of HOLD
        do_save(CMD_W'($urandom_range(0, 3)));
        do_save(CMD_W'($urandom_range(0, 3)));
        exec_pulse = 1'b1;
        tick();
        exec_pulse = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", 32'(cmd_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(cmd_valid), 32'd0);
        chk("arst_cmd_out", 32'(cmd_out), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_step", 32'(step_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        exp_q.delete();
        m_full_err = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        run_exec(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
